// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared widths, queue entry type and pend-mask decode for the writeback arbiter
package wb_arb_pkg;

   localparam int WB_XLEN = 32;
   localparam int WB_AW   = 5;

   // One secondary (MUL/DIV) writeback waiting for the register file port
   typedef struct packed {
      logic               valid;
      logic [WB_AW-1:0]   rd;
      logic [WB_XLEN-1:0] data;
   } wb_entry_t;

   // One-hot decode of a destination register for the hazard unit mask
   function automatic logic [31:0] rd_onehot(input logic [WB_AW-1:0] rd);
      logic [31:0] m;
      m     = '0;
      m[rd] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback sources, register file port and hazard signals of the arbiter
interface regfile_wb_arbiter_if #(
   parameter int XLEN = 32,
   parameter int AW   = 5
);
   logic            p_we;
   logic [AW-1:0]   p_rd;
   logic [XLEN-1:0] p_data;
   logic            s_valid;
   logic            s_ready;
   logic [AW-1:0]   s_rd;
   logic [XLEN-1:0] s_data;
   logic            rf_we;
   logic [AW-1:0]   rf_rd_addr;
   logic [XLEN-1:0] rf_rd_data;
   logic [31:0]     pend_mask;
   logic            wb_stall;

   // Pipeline side: WB stage, MUL/DIV unit, register file and hazard unit
   modport master (
      output p_we, p_rd, p_data, s_valid, s_rd, s_data,
      input  s_ready, rf_we, rf_rd_addr, rf_rd_data, pend_mask, wb_stall
   );

   // Arbiter side
   modport slave (
      input  p_we, p_rd, p_data, s_valid, s_rd, s_data,
      output s_ready, rf_we, rf_rd_addr, rf_rd_data, pend_mask, wb_stall
   );
endinterface

// File: rtl/wb_fifo2.sv
// rtl/wb_fifo2.sv - 2-entry secondary writeback queue with pop, push and kill-by-rd
module wb_fifo2
   import wb_arb_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push_i,
   input  logic [WB_AW-1:0]   push_rd_i,
   input  logic [WB_XLEN-1:0] push_data_i,
   input  logic               pop_i,
   input  logic               kill_i,
   input  logic [WB_AW-1:0]   kill_rd_i,
   output logic               full_o,
   output logic               empty_o,
   output logic [WB_AW-1:0]   head_rd_o,
   output logic [WB_XLEN-1:0] head_data_o,
   output logic [31:0]        mask_o
);

   wb_entry_t ent0_q, ent0_d;   // head
   wb_entry_t ent1_q, ent1_d;
   wb_entry_t in_e;
   logic      keep0, keep1;

   assign in_e = '{valid: 1'b1, rd: push_rd_i, data: push_data_i};

   // Drop popped/killed entries, compact survivors to the head, then append the push as youngest
   always_comb begin
      ent0_d = '0;
      ent1_d = '0;
      keep0  = ent0_q.valid && !pop_i && !(kill_i && (ent0_q.rd == kill_rd_i));
      keep1  = ent1_q.valid && !(kill_i && (ent1_q.rd == kill_rd_i));
      if (keep0) begin
         ent0_d = ent0_q;
         if (keep1) begin
            ent1_d = ent1_q;
         end
      end else if (keep1) begin
         ent0_d = ent1_q;
      end
      if (push_i) begin
         if (!ent0_d.valid) begin
            ent0_d = in_e;
         end else if (!ent1_d.valid) begin
            ent1_d = in_e;
         end
      end
   end

   // Queue storage; reset discards anything still waiting
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ent0_q <= '0;
         ent1_q <= '0;
      end else begin
         ent0_q <= ent0_d;
         ent1_q <= ent1_d;
      end
   end

   // Entries are kept compacted, so the tail being valid means full and the head invalid means empty
   assign full_o      = ent1_q.valid;
   assign empty_o     = !ent0_q.valid;
   assign head_rd_o   = ent0_q.rd;
   assign head_data_o = ent0_q.data;
   assign mask_o      = (ent0_q.valid ? rd_onehot(ent0_q.rd) : 32'h0)
                      | (ent1_q.valid ? rd_onehot(ent1_q.rd) : 32'h0);

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register file write-port arbiter (WB priority, queued MUL/DIV); optional fairness stall: WB_ARB_FAIRNESS_EN
module regfile_wb_arbiter
   import wb_arb_pkg::*;
#(
   parameter int XLEN         = WB_XLEN,
   parameter int AW           = WB_AW,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   regfile_wb_arbiter_if.slave bus
);

   logic            p_req;
   logic            grant_p;
   logic            grant_s;
   logic            push;
   logic            fifo_full;
   logic            fifo_empty;
   logic [AW-1:0]   head_rd;
   logic [XLEN-1:0] head_data;
   logic [31:0]     fifo_mask;

   logic            rf_we_q, rf_we_d;
   logic [AW-1:0]   rf_addr_q, rf_addr_d;
   logic [XLEN-1:0] rf_data_q, rf_data_d;

   // Writes to x0 are architecturally void, so they never compete for the port
   assign p_req   = bus.p_we && (bus.p_rd != '0);
   assign grant_p = p_req;
   assign grant_s = !p_req && !fifo_empty;

   // Readiness comes from the pre-pop state: a full queue refuses even while popping
   assign bus.s_ready = !fifo_full;
   assign push        = bus.s_valid && !fifo_full && (bus.s_rd != '0);

   wb_fifo2 u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (push),
      .push_rd_i   (bus.s_rd),
      .push_data_i (bus.s_data),
      .pop_i       (grant_s),
      .kill_i      (grant_p),
      .kill_rd_i   (bus.p_rd),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .head_rd_o   (head_rd),
      .head_data_o (head_data),
      .mask_o      (fifo_mask)
   );

   // Select the granted source for next cycle's register file write; address/data hold when idle
   always_comb begin
      rf_we_d   = grant_p || grant_s;
      rf_addr_d = rf_addr_q;
      rf_data_d = rf_data_q;
      if (grant_p) begin
         rf_addr_d = bus.p_rd;
         rf_data_d = bus.p_data;
      end else if (grant_s) begin
         rf_addr_d = head_rd;
         rf_data_d = head_data;
      end
   end

   // Registered register file write port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_we_q   <= 1'b0;
         rf_addr_q <= '0;
         rf_data_q <= '0;
      end else begin
         rf_we_q   <= rf_we_d;
         rf_addr_q <= rf_addr_d;
         rf_data_q <= rf_data_d;
      end
   end

   assign bus.rf_we      = rf_we_q;
   assign bus.rf_rd_addr = rf_addr_q;
   assign bus.rf_rd_data = rf_data_q;
   assign bus.pend_mask  = fifo_mask;

`ifdef WB_ARB_FAIRNESS_EN
   localparam int            CW    = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   logic [CW-1:0] starve_q, starve_d;
   logic          wb_stall_q, wb_stall_d;

   // Count cycles the queue loses to the primary; saturate at the limit and hold there while stalled
   always_comb begin
      starve_d = starve_q;
      if (grant_s || fifo_empty) begin
         starve_d = '0;
      end else if (grant_p && (starve_q != LIMIT)) begin
         starve_d = starve_q + CW'(1);
      end
      wb_stall_d = (starve_d == LIMIT);
   end

   // Starvation counter and the registered stall request to the hazard unit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_q   <= '0;
         wb_stall_q <= 1'b0;
      end else begin
         starve_q   <= starve_d;
         wb_stall_q <= wb_stall_d;
      end
   end

   assign bus.wb_stall = wb_stall_q;
`else
   logic unused_starve_limit;
   assign unused_starve_limit = (STARVE_LIMIT == 0);
   assign bus.wb_stall        = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter against a queue-based reference model
module tb_regfile_wb_arbiter;

   localparam int LIMIT = 4;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } ment_t;

   logic clk = 1'b0;
   logic rst_n;
   int   n_cmp = 0;
   int   n_bad = 0;

   ment_t       mq[$];
   logic        exp_we;
   logic [4:0]  exp_addr;
   logic [31:0] exp_data;
   int          exp_cnt;
   logic        exp_stall;

   regfile_wb_arbiter_if #(.XLEN(32), .AW(5)) bus ();

   regfile_wb_arbiter #(.XLEN(32), .AW(5), .STARVE_LIMIT(LIMIT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [31:0] model_mask();
      logic [31:0] m = '0;
      foreach (mq[i]) m = m | (32'd1 << mq[i].rd);
      return m;
   endfunction

   task automatic model_reset();
      mq.delete();
      exp_we    = 1'b0;
      exp_cnt   = 0;
      exp_stall = 1'b0;
   endtask

   // Apply one cycle of inputs, advance the reference model, and return at the next falling edge
   task automatic drive_cycle(input logic pwe, input logic [4:0] prd, input logic [31:0] pdata,
                              input logic sval, input logic [4:0] srd, input logic [31:0] sdata);
      bit    room;
      bit    was_empty;
      bit    p_req;
      bit    took_s;
      ment_t keep[$];
      bus.p_we    = pwe;
      bus.p_rd    = prd;
      bus.p_data  = pdata;
      bus.s_valid = sval;
      bus.s_rd    = srd;
      bus.s_data  = sdata;
      room      = (mq.size() < 2);
      was_empty = (mq.size() == 0);
      p_req     = pwe && (prd != 0);
      took_s    = 1'b0;
      exp_we    = 1'b0;
      if (p_req) begin
         exp_we   = 1'b1;
         exp_addr = prd;
         exp_data = pdata;
         foreach (mq[i]) if (mq[i].rd != prd) keep.push_back(mq[i]);
         mq = keep;
      end else if (!was_empty) begin
         exp_we   = 1'b1;
         exp_addr = mq[0].rd;
         exp_data = mq[0].data;
         void'(mq.pop_front());
         took_s = 1'b1;
      end
      if (sval && room && (srd != 0)) mq.push_back('{srd, sdata});
`ifdef WB_ARB_FAIRNESS_EN
      if (took_s || was_empty) exp_cnt = 0;
      else if (p_req && exp_cnt < LIMIT) exp_cnt = exp_cnt + 1;
      exp_stall = (exp_cnt == LIMIT);
`else
      exp_stall = 1'b0;
`endif
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n       = 1'b0;
      bus.p_we    = 1'b0;
      bus.p_rd    = '0;
      bus.p_data  = '0;
      bus.s_valid = 1'b1;
      bus.s_rd    = 5'd5;
      bus.s_data  = 32'hCAFE_0005;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++; if (bus.rf_we !== 1'b0) begin n_bad++; $display("FAIL rst_we: got %b want 0", bus.rf_we); end
         n_cmp++; if (bus.pend_mask !== 32'h0) begin n_bad++; $display("FAIL rst_mask: got %h want 0", bus.pend_mask); end
      end
      rst_n = 1'b1;
      model_reset();
      n_cmp++; if (bus.s_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", bus.s_ready); end
      n_cmp++; if (bus.rf_rd_addr !== 5'd0) begin n_bad++; $display("FAIL rst_addr: got %h want 0", bus.rf_rd_addr); end
      n_cmp++; if (bus.rf_rd_data !== 32'h0) begin n_bad++; $display("FAIL rst_data: got %h want 0", bus.rf_rd_data); end
      n_cmp++; if (bus.wb_stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall: got %b want 0", bus.wb_stall); end
      // reset in the middle of operation drops queued entries without writing them
      drive_cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h0000_0909);
      drive_cycle(1'b1, 5'd1, 32'h0000_0101, 1'b1, 5'd10, 32'h0000_0A0A);
      n_cmp++; if (bus.pend_mask !== 32'h0000_0600) begin n_bad++; $display("FAIL midrst_mask_before: got %h want 00000600", bus.pend_mask); end
      bus.s_valid = 1'b0;
      bus.p_we    = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (bus.pend_mask !== 32'h0) begin n_bad++; $display("FAIL midrst_mask: got %h want 0", bus.pend_mask); end
      n_cmp++; if (bus.s_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ready: got %b want 1", bus.s_ready); end
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         drive_cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
         n_cmp++; if (bus.rf_we !== 1'b0) begin n_bad++; $display("FAIL midrst_nowrite: got %b want 0", bus.rf_we); end
      end
   endtask

   task automatic test_primary();
      drive_cycle(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0);
      n_cmp++; if (bus.rf_we !== 1'b1) begin n_bad++; $display("FAIL prim_we: got %b want 1", bus.rf_we); end
      n_cmp++; if (bus.rf_rd_addr !== 5'd5) begin n_bad++; $display("FAIL prim_addr: got %0d want 5", bus.rf_rd_addr); end
      n_cmp++; if (bus.rf_rd_data !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL prim_data: got %h want deadbeef", bus.rf_rd_data); end
      drive_cycle(1'b1, 5'd0, 32'h1234_5678, 1'b0, 5'd0, 32'h0);
      n_cmp++; if (bus.rf_we !== 1'b0) begin n_bad++; $display("FAIL prim_x0_we: got %b want 0", bus.rf_we); end
   endtask

   task automatic test_queue_fill();
      n_cmp++; if (bus.s_ready !== 1'b1) begin n_bad++; $display("FAIL fill_ready0: got %b want 1", bus.s_ready); end
      drive_cycle(1'b1, 5'd1, 32'h0000_0011, 1'b1, 5'd3, 32'h3333_0003);
      n_cmp++; if (bus.s_ready !== 1'b1) begin n_bad++; $display("FAIL fill_ready1: got %b want 1", bus.s_ready); end
      drive_cycle(1'b1, 5'd1, 32'h0000_0012, 1'b1, 5'd4, 32'h4444_0004);
      n_cmp++; if (bus.s_ready !== 1'b0) begin n_bad++; $display("FAIL fill_ready2: got %b want 0", bus.s_ready); end
      n_cmp++; if (bus.pend_mask !== 32'h0000_0018) begin n_bad++; $display("FAIL fill_mask: got %h want 00000018", bus.pend_mask); end
      drive_cycle(1'b1, 5'd1, 32'h0000_0013, 1'b1, 5'd6, 32'h6666_0006);
      n_cmp++; if (bus.pend_mask !== 32'h0000_0018) begin n_bad++; $display("FAIL fill_mask_full: got %h want 00000018", bus.pend_mask); end
      n_cmp++; if (bus.rf_rd_data !== 32'h0000_0013) begin n_bad++; $display("FAIL fill_prim_data: got %h want 00000013", bus.rf_rd_data); end
      drive_cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h6666_0006);
      n_cmp++; if ({bus.rf_we, bus.rf_rd_addr, bus.rf_rd_data} !== {1'b1, 5'd3, 32'h3333_0003}) begin n_bad++; $display("FAIL fill_x3: got %b/%0d/%h want 1/3/33330003", bus.rf_we, bus.rf_rd_addr, bus.rf_rd_data); end
      drive_cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h6666_0006);
      n_cmp++; if ({bus.rf_we, bus.rf_rd_addr, bus.rf_rd_data} !== {1'b1, 5'd4, 32'h4444_0004}) begin n_bad++; $display("FAIL fill_x4: got %b/%0d/%h want 1/4/44440004", bus.rf_we, bus.rf_rd_addr, bus.rf_rd_data); end
      n_cmp++; if (bus.pend_mask !== 32'h0000_0040) begin n_bad++; $display("FAIL fill_mask6: got %h want 00000040", bus.pend_mask); end
      drive_cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      n_cmp++; if ({bus.rf_we, bus.rf_rd_addr, bus.rf_rd_data} !== {1'b1, 5'd6, 32'h6666_0006}) begin n_bad++; $display("FAIL fill_x6: got %b/%0d/%h want 1/6/66660006", bus.rf_we, bus.rf_rd_addr, bus.rf_rd_data); end
      drive_cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      n_cmp++; if (bus.rf_we !== 1'b0) begin n_bad++; $display("FAIL fill_idle: got %b want 0", bus.rf_we); end
   endtask

   task automatic test_kill();
      drive_cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h7777_7777);
      n_cmp++; if (bus.pend_mask !== 32'h0000_0080) begin n_bad++; $display("FAIL kill_mask_set: got %h want 00000080", bus.pend_mask); end
      drive_cycle(1'b1, 5'd7, 32'h0000_1234, 1'b0, 5'd0, 32'h0);
      n_cmp++; if (bus.pend_mask !== 32'h0) begin n_bad++; $display("FAIL kill_mask_clr: got %h want 0", bus.pend_mask); end
      n_cmp++; if ({bus.rf_we, bus.rf_rd_addr, bus.rf_rd_data} !== {1'b1, 5'd7, 32'h0000_1234}) begin n_bad++; $display("FAIL kill_write: got %b/%0d/%h want 1/7/00001234", bus.rf_we, bus.rf_rd_addr, bus.rf_rd_data); end
      drive_cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      n_cmp++; if (bus.rf_we !== 1'b0) begin n_bad++; $display("FAIL kill_nowrite: got %b want 0", bus.rf_we); end
   endtask

   task automatic test_rd_zero();
      n_cmp++; if (bus.s_ready !== 1'b1) begin n_bad++; $display("FAIL rd0_ready: got %b want 1", bus.s_ready); end
      drive_cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hBAD0_0000);
      n_cmp++; if (bus.pend_mask !== 32'h0) begin n_bad++; $display("FAIL rd0_mask: got %h want 0", bus.pend_mask); end
      n_cmp++; if (bus.rf_we !== 1'b0) begin n_bad++; $display("FAIL rd0_we0: got %b want 0", bus.rf_we); end
      drive_cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      n_cmp++; if (bus.rf_we !== 1'b0) begin n_bad++; $display("FAIL rd0_we1: got %b want 0", bus.rf_we); end
   endtask

`ifdef WB_ARB_FAIRNESS_EN
   task automatic test_fairness();
      drive_cycle(1'b1, 5'd2, 32'h0000_00A0, 1'b1, 5'd9, 32'h9999_0009);
      n_cmp++; if (bus.wb_stall !== 1'b0) begin n_bad++; $display("FAIL fair_start: got %b want 0", bus.wb_stall); end
      for (int k = 1; k <= LIMIT; k++) begin
         drive_cycle(1'b1, 5'd2, 32'h0000_00A0 + k, 1'b0, 5'd0, 32'h0);
         n_cmp++; if (bus.wb_stall !== (k == LIMIT)) begin n_bad++; $display("FAIL fair_count%0d: got %b want %b", k, bus.wb_stall, (k == LIMIT)); end
      end
      drive_cycle(1'b1, 5'd2, 32'h0000_00AF, 1'b0, 5'd0, 32'h0);
      n_cmp++; if ({bus.wb_stall, bus.rf_rd_addr} !== {1'b1, 5'd2}) begin n_bad++; $display("FAIL fair_hold: got %b/%0d want 1/2", bus.wb_stall, bus.rf_rd_addr); end
      drive_cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      n_cmp++; if ({bus.rf_we, bus.rf_rd_addr, bus.rf_rd_data} !== {1'b1, 5'd9, 32'h9999_0009}) begin n_bad++; $display("FAIL fair_drain: got %b/%0d/%h want 1/9/99990009", bus.rf_we, bus.rf_rd_addr, bus.rf_rd_data); end
      n_cmp++; if (bus.wb_stall !== 1'b0) begin n_bad++; $display("FAIL fair_release: got %b want 0", bus.wb_stall); end
   endtask
`endif

   task automatic test_random();
      for (int c = 0; c < 800; c++) begin
         n_cmp++; if (bus.s_ready !== (mq.size() < 2)) begin n_bad++; $display("FAIL rnd_ready c%0d: got %b want %b", c, bus.s_ready, (mq.size() < 2)); end
         n_cmp++; if (bus.pend_mask !== model_mask()) begin n_bad++; $display("FAIL rnd_mask c%0d: got %h want %h", c, bus.pend_mask, model_mask()); end
         drive_cycle($urandom_range(0, 99) < 55, 5'($urandom_range(0, 7)), $urandom,
                     $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
         n_cmp++; if (bus.rf_we !== exp_we) begin n_bad++; $display("FAIL rnd_we c%0d: got %b want %b", c, bus.rf_we, exp_we); end
         if (exp_we) begin
            n_cmp++; if ({bus.rf_rd_addr, bus.rf_rd_data} !== {exp_addr, exp_data}) begin n_bad++; $display("FAIL rnd_write c%0d: got %0d/%h want %0d/%h", c, bus.rf_rd_addr, bus.rf_rd_data, exp_addr, exp_data); end
         end
         n_cmp++; if (bus.wb_stall !== exp_stall) begin n_bad++; $display("FAIL rnd_stall c%0d: got %b want %b", c, bus.wb_stall, exp_stall); end
      end
   endtask

   initial begin
      test_reset();
      test_primary();
      test_queue_fill();
      test_kill();
      test_rd_zero();
`ifdef WB_ARB_FAIRNESS_EN
      test_fairness();
`endif
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
